// File: rtl/ttt_move_gen.sv
// Tic-tac-toe computer move generator. It scans the board in three phases:
// complete its own line (WIN), block a player line (BLOCK), then take a preferred cell (PREF).
module ttt_move_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [8:0] board_x,
    input  logic [8:0] board_o,
    input  logic       ack,
    output logic [3:0] comp_pos,
    output logic       move_valid,
    output logic       no_move,
    output logic       illegal,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WIN   = 3'd1,
        S_BLOCK = 3'd2,
        S_PREF  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [8:0] bx_q, bx_d;
    logic [8:0] bo_q, bo_d;
    logic [3:0] comp_pos_q, comp_pos_d;
    logic       no_move_q, no_move_d;
    logic       illegal_q, illegal_d;

    // Cell indices are 0-based (position - 1); packed as {c2, c1, c0}.
    function automatic logic [11:0] line_table(input logic [2:0] k);
        case (k)
            3'd0:    line_table = {4'd2, 4'd1, 4'd0};
            3'd1:    line_table = {4'd5, 4'd4, 4'd3};
            3'd2:    line_table = {4'd8, 4'd7, 4'd6};
            3'd3:    line_table = {4'd6, 4'd3, 4'd0};
            3'd4:    line_table = {4'd7, 4'd4, 4'd1};
            3'd5:    line_table = {4'd8, 4'd5, 4'd2};
            3'd6:    line_table = {4'd8, 4'd4, 4'd0};
            default: line_table = {4'd6, 4'd4, 4'd2};
        endcase
    endfunction

    // Preference order centre, corners, edges (positions 5,1,3,7,9,2,4,6,8).
    function automatic logic [3:0] pref_table(input logic [3:0] p);
        case (p)
            4'd0:    pref_table = 4'd4;
            4'd1:    pref_table = 4'd0;
            4'd2:    pref_table = 4'd2;
            4'd3:    pref_table = 4'd6;
            4'd4:    pref_table = 4'd8;
            4'd5:    pref_table = 4'd1;
            4'd6:    pref_table = 4'd3;
            4'd7:    pref_table = 4'd5;
            default: pref_table = 4'd7;
        endcase
    endfunction

    logic [8:0] own;
    logic [8:0] occ;
    logic [3:0] c0, c1, c2;
    logic [3:0] pref_cell;
    logic       hit;
    logic [3:0] hit_cell;

    always_comb begin
        own       = (state_q == S_WIN) ? bo_q : bx_q;
        occ       = bx_q | bo_q;
        {c2, c1, c0} = line_table(idx_q[2:0]);
        pref_cell = pref_table(idx_q);
        hit       = 1'b0;
        hit_cell  = 4'd0;
        if (own[c0] && own[c1] && !occ[c2]) begin
            hit      = 1'b1;
            hit_cell = c2;
        end else if (own[c0] && own[c2] && !occ[c1]) begin
            hit      = 1'b1;
            hit_cell = c1;
        end else if (own[c1] && own[c2] && !occ[c0]) begin
            hit      = 1'b1;
            hit_cell = c0;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bx_d       = bx_q;
        bo_d       = bo_q;
        comp_pos_d = comp_pos_q;
        no_move_d  = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                comp_pos_d = 4'd0;
                if (req) begin
                    bx_d    = board_x;
                    bo_d    = board_o;
                    idx_d   = 4'd0;
                    state_d = S_WIN;
                end
            end
            S_WIN, S_BLOCK: begin
                // Overlap is only possible on the first WIN cycle after a latch.
                if (state_q == S_WIN && (bx_q & bo_q) != 9'd0) begin
                    illegal_d = 1'b1;
                    idx_d     = 4'd0;
                    state_d   = S_IDLE;
                end else if (hit) begin
                    comp_pos_d = hit_cell + 4'd1;
                    state_d    = S_DONE;
                end else if (idx_q == 4'd7) begin
                    idx_d   = 4'd0;
                    state_d = (state_q == S_WIN) ? S_BLOCK : S_PREF;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_PREF: begin
                // Index 9 is the extra cycle that reports a full board.
                if (idx_q == 4'd9) begin
                    no_move_d = 1'b1;
                    idx_d     = 4'd0;
                    state_d   = S_IDLE;
                end else if (!occ[pref_cell]) begin
                    comp_pos_d = pref_cell + 4'd1;
                    state_d    = S_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                if (ack) begin
                    comp_pos_d = 4'd0;
                    idx_d      = 4'd0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                comp_pos_d = 4'd0;
                idx_d      = 4'd0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            bx_q       <= 9'd0;
            bo_q       <= 9'd0;
            comp_pos_q <= 4'd0;
            no_move_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bx_q       <= bx_d;
            bo_q       <= bo_d;
            comp_pos_q <= comp_pos_d;
            no_move_q  <= no_move_d;
            illegal_q  <= illegal_d;
        end
    end

    assign comp_pos   = comp_pos_q;
    assign move_valid = (state_q == S_DONE);
    assign no_move    = no_move_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q != S_IDLE);

endmodule
